// File: rtl/scaler_ctrl_pkg.sv
// scaler_ctrl_pkg: shared definitions for the scaler control block.
//   - host register address map
//   - control register bit positions
//   - FSM state type
//   - origin clamp helper
package scaler_ctrl_pkg;

  localparam logic [2:0] ADDR_X_LO  = 3'd0;
  localparam logic [2:0] ADDR_X_HI  = 3'd1;
  localparam logic [2:0] ADDR_Y_LO  = 3'd2;
  localparam logic [2:0] ADDR_Y_HI  = 3'd3;
  localparam logic [2:0] ADDR_ZOOM  = 3'd4;
  localparam logic [2:0] ADDR_DX    = 3'd5;
  localparam logic [2:0] ADDR_DY    = 3'd6;
  localparam logic [2:0] ADDR_CTRL  = 3'd7;

  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_PAN_BIT    = 1;

  localparam logic [2:0] ZOOM_MAX = 3'd4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Saturate an 11-bit origin to the last valid cell index.
  function automatic logic [10:0] clamp_origin(input logic [10:0] v,
                                               input logic [10:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/scaler_ctrl_wrap.sv
// scaler_ctrl_wrap: one auto-pan step, origin + signed step modulo MAX.
//   i_val  [10:0]  current origin, assumed in [0, MAX)
//   i_step [7:0]   signed step
//   o_val  [10:0]  wrapped origin, single correction by MAX
module scaler_ctrl_wrap #(
  parameter int unsigned MAX = 1920
) (
  input  logic [10:0] i_val,
  input  logic [7:0]  i_step,
  output logic [10:0] o_val
);

  logic [12:0] w_sum;

  assign w_sum = {2'b00, i_val} + {{5{i_step[7]}}, i_step};

  // Result lies in [0, MAX) after one correction, so 11-bit modular
  // arithmetic on the low bits yields the exact value.
  always_comb begin
    o_val = w_sum[10:0];
    if (w_sum[12]) begin
      o_val = w_sum[10:0] + 11'(MAX);
    end else if (w_sum >= 13'(MAX)) begin
      o_val = w_sum[10:0] - 11'(MAX);
    end
  end

endmodule

// File: rtl/scaler_ctrl.sv
// scaler_ctrl: host-programmable scaler window with frame-synchronous commit.
//   clk_in, rst_n (async, active low)
//   frame_start         start-of-frame pulse
//   reg_wr/reg_rd       host strobes; reg_addr[2:0], reg_wdata[7:0]
//   reg_rdata[7:0]      registered read data
//   scaler_x_origin/scaler_y_origin[10:0], scaler_zoom[2:0], scaler_border
//   pending             commit queued, waiting for frame_start
// Optional feature: define SCALER_CTRL_AUTO_PAN_EN for per-frame auto-pan.
module scaler_ctrl
  import scaler_ctrl_pkg::*;
#(
  parameter int unsigned H_LIFE = 1920,
  parameter int unsigned V_LIFE = 1080
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [2:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic [10:0] scaler_x_origin,
  output logic [10:0] scaler_y_origin,
  output logic [2:0]  scaler_zoom,
  output logic        scaler_border,
  output logic        pending
);

  localparam logic [10:0] X_LIM = 11'(H_LIFE - 1);
  localparam logic [10:0] Y_LIM = 11'(V_LIFE - 1);
  localparam logic [10:0] X_RST = 11'(H_LIFE / 2);
  localparam logic [10:0] Y_RST = 11'(V_LIFE / 2);

  state_t      r_state, w_state_nxt;
  logic        w_commit, w_apply;
  logic [10:0] r_sh_x, r_sh_y;
  logic [2:0]  r_sh_zoom;
  logic        r_sh_border;
  logic [10:0] r_act_x, r_act_y;
  logic [2:0]  r_act_zoom;
  logic        r_act_border;
  logic [7:0]  r_rdata, w_rd_mux;
`ifdef SCALER_CTRL_AUTO_PAN_EN
  logic [7:0]  r_sh_dx, r_sh_dy;
  logic        r_pan_en;
  logic        w_pan_step;
  logic [10:0] w_pan_x, w_pan_y;
`endif

  assign w_commit = reg_wr && (reg_addr == ADDR_CTRL) && reg_wdata[CTRL_COMMIT_BIT];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A commit coinciding with frame_start is applied immediately and never
  // enters PENDING.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_commit && frame_start) w_apply = 1'b1;
        else if (w_commit)           w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_start) begin
          w_apply     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SCALER_CTRL_AUTO_PAN_EN
  assign w_pan_step = frame_start && !w_apply && (r_state == ST_IDLE) && r_pan_en;

  scaler_ctrl_wrap #(.MAX(H_LIFE)) u_wrap_x (
    .i_val (r_act_x),
    .i_step(r_sh_dx),
    .o_val (w_pan_x)
  );

  scaler_ctrl_wrap #(.MAX(V_LIFE)) u_wrap_y (
    .i_val (r_act_y),
    .i_step(r_sh_dy),
    .o_val (w_pan_y)
  );
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_x      <= '0;
      r_sh_y      <= '0;
      r_sh_zoom   <= '0;
      r_sh_border <= 1'b0;
`ifdef SCALER_CTRL_AUTO_PAN_EN
      r_sh_dx     <= '0;
      r_sh_dy     <= '0;
      r_pan_en    <= 1'b0;
`endif
    end else if (reg_wr) begin
      case (reg_addr)
        ADDR_X_LO: r_sh_x <= clamp_origin({r_sh_x[10:8], reg_wdata}, X_LIM);
        ADDR_X_HI: r_sh_x <= clamp_origin({reg_wdata[2:0], r_sh_x[7:0]}, X_LIM);
        ADDR_Y_LO: r_sh_y <= clamp_origin({r_sh_y[10:8], reg_wdata}, Y_LIM);
        ADDR_Y_HI: r_sh_y <= clamp_origin({reg_wdata[2:0], r_sh_y[7:0]}, Y_LIM);
        ADDR_ZOOM: begin
          r_sh_zoom   <= (reg_wdata[2:0] > ZOOM_MAX) ? ZOOM_MAX : reg_wdata[2:0];
          r_sh_border <= reg_wdata[3];
        end
`ifdef SCALER_CTRL_AUTO_PAN_EN
        ADDR_DX:   r_sh_dx  <= reg_wdata;
        ADDR_DY:   r_sh_dy  <= reg_wdata;
        ADDR_CTRL: r_pan_en <= reg_wdata[CTRL_PAN_BIT];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_act_x      <= X_RST;
      r_act_y      <= Y_RST;
      r_act_zoom   <= 3'd1;
      r_act_border <= 1'b0;
    end else if (w_apply) begin
      r_act_x      <= r_sh_x;
      r_act_y      <= r_sh_y;
      r_act_zoom   <= r_sh_zoom;
      r_act_border <= r_sh_border;
    end
`ifdef SCALER_CTRL_AUTO_PAN_EN
    else if (w_pan_step) begin
      r_act_x <= w_pan_x;
      r_act_y <= w_pan_y;
    end
`endif
  end

  always_comb begin
    w_rd_mux = '0;
    case (reg_addr)
      ADDR_X_LO: w_rd_mux = r_sh_x[7:0];
      ADDR_X_HI: w_rd_mux = {5'b0, r_sh_x[10:8]};
      ADDR_Y_LO: w_rd_mux = r_sh_y[7:0];
      ADDR_Y_HI: w_rd_mux = {5'b0, r_sh_y[10:8]};
      ADDR_ZOOM: w_rd_mux = {4'b0, r_sh_border, r_sh_zoom};
`ifdef SCALER_CTRL_AUTO_PAN_EN
      ADDR_DX:   w_rd_mux = r_sh_dx;
      ADDR_DY:   w_rd_mux = r_sh_dy;
      ADDR_CTRL: w_rd_mux = {6'b0, r_pan_en, (r_state == ST_PENDING)};
`else
      ADDR_CTRL: w_rd_mux = {7'b0, (r_state == ST_PENDING)};
`endif
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)      r_rdata <= '0;
    else if (reg_rd) r_rdata <= w_rd_mux;
  end

  assign reg_rdata       = r_rdata;
  assign scaler_x_origin = r_act_x;
  assign scaler_y_origin = r_act_y;
  assign scaler_zoom     = r_act_zoom;
  assign scaler_border   = r_act_border;
  assign pending         = (r_state == ST_PENDING);

endmodule

// File: doc/scaler_ctrl.md
SCALER_CTRL -- requirements
Module: scaler_ctrl

Interface
REQ-001 Parameter H_LIFE, default 1920, life playfield width in cells.
REQ-002 Parameter V_LIFE, default 1080, life playfield height in cells.
REQ-003 clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 frame_start  input  1  one-cycle pulse when life_h_counter==0 and life_v_counter==0.
REQ-006 reg_wr  input  1  host register write strobe, one cycle per write.
REQ-007 reg_rd  input  1  host register read strobe.
REQ-008 reg_addr  input  3  register index, 0-7.
REQ-009 reg_wdata  input  8  write data.
REQ-010 reg_rdata  output  8  read data, registered.
REQ-011 scaler_x_origin  output  11  active window centre X.
REQ-012 scaler_y_origin  output  11  active window centre Y.
REQ-013 scaler_zoom  output  3  active zoom, 0-4.
REQ-014 scaler_border  output  1  active border enable.
REQ-015 pending  output  1  high while a committed update awaits frame_start.

Function
REQ-016 Register map: 0 X[7:0]; 1 X[10:8] in bits 2:0; 2 Y[7:0]; 3 Y[10:8] in bits 2:0; 4 zoom[2:0] and border in bit 3; 5 DX signed 8-bit; 6 DY signed 8-bit; 7 control.
REQ-017 Registers 0-6 write shadow copies only; the active outputs never change on a host write.
REQ-018 Control write: bit0=1 requests commit; bit1 stores auto-pan enable; other bits ignored.
REQ-019 Control read: bit0=pending, bit1=auto-pan enable, bits 7:2=0.
REQ-020 reg_rdata is valid one cycle after reg_rd and returns shadow values for registers 0-6; unused bits read 0.
REQ-021 Zoom writes of 5-7 store 4.
REQ-022 X shadow values >= H_LIFE, assessed after each register 0/1 write, clamp to H_LIFE-1; Y values >= V_LIFE clamp to V_LIFE-1.
REQ-023 FSM states: IDLE, PENDING. IDLE->PENDING on commit; PENDING->IDLE on frame_start, which loads all shadows into the active outputs.
REQ-024 Active outputs update on the cycle after frame_start (latency 1).
REQ-025 Commit and frame_start in the same cycle: the update is applied at that frame_start.
REQ-026 Shadow writes while PENDING are allowed; the value present on the frame_start cycle is the value applied.
REQ-027 A repeated commit while PENDING has no further effect.
REQ-028 Auto-pan: on frame_start in IDLE with enable=1, X += sign-extended DX modulo H_LIFE and Y += sign-extended DY modulo V_LIFE.
REQ-029 Modulo wrap: a result < 0 adds H_LIFE (or V_LIFE); a result >= H_LIFE (or V_LIFE) subtracts it; exactly one correction is applied per frame.
REQ-030 A frame_start that applies a commit performs no pan step that frame.
REQ-031 Auto-pan updates the active origin only; the shadow X/Y values are not modified.

Reset
REQ-032 While rst_n is low, the FSM is in IDLE.
REQ-033 While rst_n is low, pending=0 and reg_rdata=0.
REQ-034 While rst_n is low, all shadow registers are 0 and auto-pan enable is 0.
REQ-035 While rst_n is low, active X=H_LIFE/2, Y=V_LIFE/2, zoom=1 and border=0.
REQ-036 Reset asserted while PENDING discards the queued update.

Configuration
REQ-037 Macro SCALER_CTRL_AUTO_PAN_EN defined: registers 5-6 and control bit1 behave as above.
REQ-038 Macro SCALER_CTRL_AUTO_PAN_EN undefined: pan logic is absent, registers 5-6 and control bit1 read 0, writes to them are ignored, and the origin changes only by commit.

Structure
REQ-039 Package scaler_ctrl_pkg holds the register address constants, the control bit positions and the FSM state type.
REQ-040 Sub-module scaler_ctrl_wrap (signed step, modulo add, MAX parameter) is instantiated once for X and once for Y, only when SCALER_CTRL_AUTO_PAN_EN is defined.

Verification
REQ-041 Reset release -> X=960, Y=540, zoom=1, border=0, pending=0.
REQ-042 Write X=0x190/Y=0x12C/zoom=3/border=1, then commit -> pending=1 and outputs unchanged; frame_start -> outputs become 400/300/3/1 one cycle later and pending=0.
REQ-043 Commit coincident with frame_start -> outputs update at that frame_start and pending is never observed high after it.
REQ-044 Zoom write of 7 -> reads back 4; X write of 2000 -> reads back 1919.
REQ-045 Auto-pan with active X=1910, DX=+20 -> X=10 after one frame_start; active Y=5, DY=-10 -> Y=1075.
REQ-046 rst_n pulsed low while PENDING, then frame_start -> outputs hold reset values.
